// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: register addressing, tracker entry layout and
// forwarding encoding, plus small helpers used by the hazard logic.
package cpu_pkg;

   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] X0 = '0;
   localparam int FWD_RB = 0;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regWrite;
      logic              memRead;
      logic              memWrite;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              useRs1;
      logic              useRs2;
   } trackEntry_t;

   function automatic logic isWriter(input trackEntry_t e);
      return e.valid && e.regWrite && (e.rd != X0);
   endfunction

   // True when entry e produces the value a consumer reads through src.
   function automatic logic writesSrc(input trackEntry_t e,
                                      input logic [REG_AW-1:0] src,
                                      input logic useSrc);
      return isWriter(e) && useSrc && (e.rd == src);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clear)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and forwarding controller: shadows in-flight instructions from EX to WB
// and derives stall, bubble, flush, freeze and forwarding selects from them.
module pipeline_ctrl #(
   parameter int DEPTH  = 3,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32,
   parameter int FW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              ex_redirect,
   input  logic              mem_done,
   output logic              stall_if,
   output logic              stall_id,
   output logic              bubble_ex,
   output logic              flush_if,
   output logic              flush_id,
   output logic              freeze_back,
   output logic [FW-1:0]     fwd_sel_rs1,
   output logic [FW-1:0]     fwd_sel_rs2,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   import cpu_pkg::*;

   localparam int MEM_IDX = DEPTH - 2;
   localparam int WB_IDX  = DEPTH - 1;

   trackEntry_t tracker [DEPTH];
   trackEntry_t idEntry;

   logic memStall;
   logic loadUse;
   logic redirect;
   logic issue;
   logic stallInc;
   logic counterClear;

   always_comb begin
      idEntry          = '0;
      idEntry.valid    = id_valid;
      idEntry.rd       = id_rd;
      idEntry.regWrite = id_reg_write;
      idEntry.memRead  = id_mem_read;
      idEntry.memWrite = id_mem_write;
      idEntry.rs1      = id_rs1;
      idEntry.rs2      = id_rs2;
      idEntry.useRs1   = id_use_rs1;
      idEntry.useRs2   = id_use_rs2;
   end

   // Loads only forward from WB, so a load anywhere before MEM blocks a dependent ID.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      memStall = tracker[MEM_IDX].valid
               && (tracker[MEM_IDX].memRead || tracker[MEM_IDX].memWrite)
               && !mem_done;
      loadUse = 1'b0;
      for (int k = 0; k < MEM_IDX; k++) begin
         if (tracker[k].memRead
             && (writesSrc(tracker[k], id_rs1, id_use_rs1)
                 || writesSrc(tracker[k], id_rs2, id_use_rs2)))
            loadUse = 1'b1;
      end
      loadUse  = loadUse && id_valid;
      redirect = !memStall && ex_redirect;
      issue    = id_valid && !loadUse && !redirect;
   end

   assign freeze_back = memStall;
   assign flush_if    = redirect;
   assign flush_id    = redirect;
   assign stall_if    = memStall || (loadUse && !redirect);
   assign stall_id    = stall_if;
   assign bubble_ex   = redirect || (loadUse && !memStall);

   // Walk from WB towards EX so the youngest matching writer wins.
   always_comb begin
      fwd_sel_rs1 = FW'(FWD_RB);
      fwd_sel_rs2 = FW'(FWD_RB);
      for (int k = WB_IDX; k >= 1; k--) begin
         if ((k == WB_IDX) || !tracker[k].memRead) begin
            if (writesSrc(tracker[k], tracker[0].rs1, tracker[0].useRs1))
               fwd_sel_rs1 = FW'(k);
            if (writesSrc(tracker[k], tracker[0].rs2, tracker[0].useRs2))
               fwd_sel_rs2 = FW'(k);
         end
      end
      if (!tracker[0].valid || (tracker[0].rs1 == X0))
         fwd_sel_rs1 = FW'(FWD_RB);
      if (!tracker[0].valid || (tracker[0].rs2 == X0))
         fwd_sel_rs2 = FW'(FWD_RB);
   end

   // NOTE: the whole tracker is a handful of flops, so every entry is cleared on reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++)
            tracker[k] <= '0;
      end else if (!memStall) begin
         tracker[0] <= issue ? idEntry : '0;
         for (int k = 1; k < DEPTH; k++)
            tracker[k] <= tracker[k-1];
      end
   end

   assign stallInc     = stall_id && !flush_id;
   assign counterClear = !rst;

   sat_counter #(.W(CNT_W)) uStallCount (
      .clk   (clk),
      .inc   (stallInc),
      .clear (counterClear),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) uFlushCount (
      .clk   (clk),
      .inc   (redirect),
      .clear (counterClear),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: vector table on a DEPTH=3 controller, hand sequences on a
// DEPTH=5 / 2-bit-counter build for priority, saturation and mid-stall reset.
module tb_pipeline_ctrl;

   typedef struct packed {
      logic       idValid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       useRs1;
      logic       useRs2;
      logic [4:0] rd;
      logic       regWrite;
      logic       memRead;
      logic       memWrite;
      logic       exRedirect;
      logic       memDone;
   } stim_t;

   // ctrl = {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze_back}
   typedef struct packed {
      logic [5:0]  ctrl;
      logic [2:0]  fwd1;
      logic [2:0]  fwd2;
      logic [31:0] sc;
      logic [31:0] fc;
   } obs_t;

   typedef struct packed {
      stim_t s;
      obs_t  e;
   } vec_t;

   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_LU   = 6'b111000;
   localparam logic [5:0] C_RD   = 6'b001110;
   localparam logic [5:0] C_MS   = 6'b110001;

   logic  clk = 1'b0;
   logic  rst = 1'b0;
   stim_t s3;
   stim_t s5;

   logic        sIf3, sId3, bub3, fIf3, fId3, frz3;
   logic [1:0]  f1_3, f2_3;
   logic [31:0] sc3, fc3;
   logic        sIf5, sId5, bub5, fIf5, fId5, frz5;
   logic [2:0]  f1_5, f2_5;
   logic [1:0]  sc5, fc5;

   obs_t expQ [$];
   int   vecCount  = 0;
   int   missCount = 0;
   vec_t tbl [22];

   always #5 clk = ~clk;

   pipeline_ctrl #(.DEPTH(3), .REG_AW(5), .CNT_W(32)) dut3 (
      .clk(clk), .rst(rst),
      .id_valid(s3.idValid), .id_rs1(s3.rs1), .id_rs2(s3.rs2),
      .id_use_rs1(s3.useRs1), .id_use_rs2(s3.useRs2), .id_rd(s3.rd),
      .id_reg_write(s3.regWrite), .id_mem_read(s3.memRead), .id_mem_write(s3.memWrite),
      .ex_redirect(s3.exRedirect), .mem_done(s3.memDone),
      .stall_if(sIf3), .stall_id(sId3), .bubble_ex(bub3),
      .flush_if(fIf3), .flush_id(fId3), .freeze_back(frz3),
      .fwd_sel_rs1(f1_3), .fwd_sel_rs2(f2_3),
      .stall_count(sc3), .flush_count(fc3)
   );

   pipeline_ctrl #(.DEPTH(5), .REG_AW(5), .CNT_W(2)) dut5 (
      .clk(clk), .rst(rst),
      .id_valid(s5.idValid), .id_rs1(s5.rs1), .id_rs2(s5.rs2),
      .id_use_rs1(s5.useRs1), .id_use_rs2(s5.useRs2), .id_rd(s5.rd),
      .id_reg_write(s5.regWrite), .id_mem_read(s5.memRead), .id_mem_write(s5.memWrite),
      .ex_redirect(s5.exRedirect), .mem_done(s5.memDone),
      .stall_if(sIf5), .stall_id(sId5), .bubble_ex(bub5),
      .flush_if(fIf5), .flush_id(fId5), .freeze_back(frz5),
      .fwd_sel_rs1(f1_5), .fwd_sel_rs2(f2_5),
      .stall_count(sc5), .flush_count(fc5)
   );

   function automatic stim_t idle();
      stim_t s = '0;
      s.memDone = 1'b1;
      return s;
   endfunction

   function automatic stim_t ins(input int rd, input int rs1, input int rs2,
                                 input bit u1, input bit u2,
                                 input bit rw, input bit mr, input bit mw);
      stim_t s = idle();
      s.idValid  = 1'b1;
      s.rd       = 5'(rd);
      s.rs1      = 5'(rs1);
      s.rs2      = 5'(rs2);
      s.useRs1   = u1;
      s.useRs2   = u2;
      s.regWrite = rw;
      s.memRead  = mr;
      s.memWrite = mw;
      return s;
   endfunction

   function automatic stim_t ctl(input stim_t s, input bit redir, input bit done);
      stim_t r = s;
      r.exRedirect = redir;
      r.memDone    = done;
      return r;
   endfunction

   function automatic obs_t o(input logic [5:0] c, input int f1, input int f2,
                              input int sc, input int fc);
      obs_t r;
      r.ctrl = c;
      r.fwd1 = 3'(f1);
      r.fwd2 = 3'(f2);
      r.sc   = 32'(sc);
      r.fc   = 32'(fc);
      return r;
   endfunction

   function automatic obs_t sampleObs(input bit five);
      obs_t r;
      if (five) begin
         r.ctrl = {sIf5, sId5, bub5, fIf5, fId5, frz5};
         r.fwd1 = f1_5;
         r.fwd2 = f2_5;
         r.sc   = {30'b0, sc5};
         r.fc   = {30'b0, fc5};
      end else begin
         r.ctrl = {sIf3, sId3, bub3, fIf3, fId3, frz3};
         r.fwd1 = {1'b0, f1_3};
         r.fwd2 = {1'b0, f2_3};
         r.sc   = sc3;
         r.fc   = fc3;
      end
      return r;
   endfunction

   task automatic setVec(input int i, input stim_t s, input obs_t e);
      tbl[i].s = s;
      tbl[i].e = e;
   endtask

   // Drive now, queue the expectation, compare on the falling edge.
   task automatic driveCheck(input bit five, input stim_t s, input obs_t e, input string name);
      obs_t got;
      obs_t want;
      if (five) s5 = s; else s3 = s;
      expQ.push_back(e);
      @(negedge clk);
      got = sampleObs(five);
      vecCount++;
      if (expQ.size() == 0) begin
         missCount++;
         $display("FAIL %s: scoreboard empty, got %h", name, got);
      end else begin
         want = expQ.pop_front();
         if (got !== want) begin
            missCount++;
            $display("FAIL %s: got ctrl=%b fwd=%0d/%0d sc=%0d fc=%0d, want ctrl=%b fwd=%0d/%0d sc=%0d fc=%0d",
                     name, got.ctrl, got.fwd1, got.fwd2, got.sc, got.fc,
                     want.ctrl, want.fwd1, want.fwd2, want.sc, want.fc);
         end
      end
   endtask

   task automatic runVec(input bit five, input stim_t s, input obs_t e, input string name);
      @(posedge clk);
      #1;
      driveCheck(five, s, e, name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   initial begin
      stim_t addX10;
      stim_t lw7;
      stim_t use7;
      stim_t wait13;

      s3 = idle();
      s5 = idle();
      lw7    = ins(7, 1, 0, 1, 0, 1, 1, 0);
      wait13 = ins(13, 12, 3, 1, 1, 1, 0, 0);

      setVec(0,  idle(),                                 o(C_NONE, 0, 0, 0, 0));
      setVec(1,  ins(5, 1, 2, 1, 1, 1, 0, 0),            o(C_NONE, 0, 0, 0, 0));
      setVec(2,  ins(6, 5, 1, 1, 1, 1, 0, 0),            o(C_NONE, 0, 0, 0, 0));
      setVec(3,  idle(),                                 o(C_NONE, 1, 0, 0, 0));
      setVec(4,  lw7,                                    o(C_NONE, 0, 0, 0, 0));
      setVec(5,  ins(8, 7, 7, 1, 1, 1, 0, 0),            o(C_LU,   0, 0, 0, 0));
      setVec(6,  ins(8, 7, 7, 1, 1, 1, 0, 0),            o(C_NONE, 0, 0, 1, 0));
      setVec(7,  idle(),                                 o(C_NONE, 2, 2, 1, 0));
      setVec(8,  ins(0, 1, 0, 1, 0, 1, 0, 0),            o(C_NONE, 0, 0, 1, 0));
      setVec(9,  ins(9, 0, 0, 1, 1, 1, 0, 0),            o(C_NONE, 0, 0, 1, 0));
      setVec(10, idle(),                                 o(C_NONE, 0, 0, 1, 0));
      setVec(11, ins(10, 1, 0, 1, 0, 1, 1, 0),           o(C_NONE, 0, 0, 1, 0));
      setVec(12, ctl(ins(11, 10, 2, 1, 1, 1, 0, 0), 1, 1), o(C_RD, 0, 0, 1, 0));
      setVec(13, idle(),                                 o(C_NONE, 0, 0, 1, 1));
      setVec(14, ins(0, 1, 2, 1, 1, 0, 0, 1),            o(C_NONE, 0, 0, 1, 1));
      setVec(15, ins(12, 3, 4, 1, 1, 1, 0, 0),           o(C_NONE, 0, 0, 1, 1));
      setVec(16, ctl(wait13, 0, 0),                      o(C_MS,   0, 0, 1, 1));
      setVec(17, ctl(wait13, 1, 0),                      o(C_MS,   0, 0, 2, 1));
      setVec(18, ctl(wait13, 1, 0),                      o(C_MS,   0, 0, 3, 1));
      setVec(19, ctl(wait13, 1, 1),                      o(C_RD,   0, 0, 4, 1));
      setVec(20, ins(14, 12, 0, 1, 0, 1, 0, 0),          o(C_NONE, 0, 0, 4, 2));
      setVec(21, idle(),                                 o(C_NONE, 2, 0, 4, 2));

      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 22; i++)
         runVec(1'b0, tbl[i].s, tbl[i].e, $sformatf("d3_vec%0d", i));
      s3 = idle();

      // Writers to x5 at k=1 and k=3: the younger one must win.
      runVec(1'b1, ins(5, 1, 2, 1, 1, 1, 0, 0), o(C_NONE, 0, 0, 0, 0), "d5_writerA");
      runVec(1'b1, idle(),                      o(C_NONE, 0, 0, 0, 0), "d5_gap");
      runVec(1'b1, ins(5, 3, 4, 1, 1, 1, 0, 0), o(C_NONE, 0, 0, 0, 0), "d5_writerB");
      runVec(1'b1, ins(6, 5, 5, 1, 1, 1, 0, 0), o(C_NONE, 0, 0, 0, 0), "d5_consumer");
      runVec(1'b1, idle(),                      o(C_NONE, 1, 1, 0, 0), "d5_nearest");

      // Load-use with the load sitting at k=0,1,2 stalls three cycles, reaching saturation.
      use7 = ins(8, 7, 0, 1, 0, 1, 0, 0);
      runVec(1'b1, lw7,  o(C_NONE, 0, 0, 0, 0), "d5_lw");
      runVec(1'b1, use7, o(C_LU,   0, 0, 0, 0), "d5_lu_k0");
      runVec(1'b1, use7, o(C_LU,   0, 0, 1, 0), "d5_lu_k1");
      runVec(1'b1, use7, o(C_LU,   0, 0, 2, 0), "d5_lu_k2");
      runVec(1'b1, use7, o(C_NONE, 0, 0, 3, 0), "d5_lu_release");
      runVec(1'b1, ins(9, 1, 0, 1, 0, 1, 1, 0), o(C_NONE, 4, 0, 3, 0), "d5_fwd_wb_load");
      addX10 = ins(10, 9, 9, 1, 1, 1, 0, 0);
      runVec(1'b1, addX10, o(C_LU, 0, 0, 3, 0), "d5_sat_hold");
      runVec(1'b1, addX10, o(C_LU, 0, 0, 3, 0), "d5_sat_hold2");

      // Reset while the load-use stall is still active.
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      driveCheck(1'b1, addX10, o(C_NONE, 0, 0, 0, 0), "d5_reset_mid_stall");

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline (IF, ID, EX, MEM…WB).
- Keeps a shadow tracker of every in-flight instruction from EX through WB, tagged with rd, write and load/store flags.
- From the tracker it drives stall, bubble and flush for the front end and forwarding selects for the EX operands.
- Replaces the ad-hoc wiring of RegWrite/RegDest through every stage, and adds stall/flush performance counters.

Parameters:
DEPTH, 3, tracked stages from EX to WB inclusive (3 = EX, MEM, WB); must be ≥3; index 0 = EX, DEPTH-2 = MEM, DEPTH-1 = WB
REG_AW, 5, register address width
CNT_W, 32, performance counter width
FW, $clog2(DEPTH), width of forwarding select

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  REG_AW  ID source registers
id_use_rs1, id_use_rs2  in  1  source actually read
id_rd  in  REG_AW  ID destination
id_reg_write, id_mem_read, id_mem_write  in  1  ID control flags
ex_redirect  in  1  EX resolved a taken branch/jump this cycle
mem_done  in  1  memory stage finished its access
stall_if, stall_id  out  1  hold PC / IF-ID register
bubble_ex  out  1  load NOP into ID-EX register
flush_if, flush_id  out  1  squash IF and ID contents
freeze_back  out  1  hold EX, MEM, WB registers
fwd_sel_rs1, fwd_sel_rs2  out  FW  0 = register bank, k = forward from tracked stage k (k ≥ 1)
stall_count, flush_count  out  CNT_W  saturating counters

Behaviour:
- Tracker entry fields: valid, rd, reg_write, mem_read, mem_write, rs1, rs2, use_rs1, use_rs2.
- Reset (rst == 0 at posedge): all entries invalid, counters 0.
- All outputs are combinational from the tracker and inputs; all are 0 while the tracker is empty and inputs are idle.
- Terms used below: "writer" = valid && reg_write && rd != 0; "match" = a writer whose rd equals a used source register.
- mem_stall = entry[DEPTH-2].valid && (mem_read || mem_write) && !mem_done.
  - Effect: freeze_back = stall_if = stall_id = 1, and the tracker holds.
  - ex_redirect is ignored while mem_stall is high; EX re-presents it after release.
- load_use: any entry k < DEPTH-2 that is valid && mem_read and matches id_rs1/id_rs2 (used), with id_valid.
  - Loads are forwardable only from WB.
  - Effect when !mem_stall: stall_if = stall_id = bubble_ex = 1.
- redirect, when !mem_stall && ex_redirect: flush_if = flush_id = 1 and bubble_ex = 1.
  - Redirect overrides load_use; stall_if/stall_id are 0 so the new PC loads.
- Priority: mem_stall > redirect > load_use > normal.
- Advance (every posedge with !mem_stall): entry[k+1] <= entry[k].
  - entry[0] <= ID fields when id_valid and not (load_use or redirect); otherwise an invalid bubble.
  - The old WB entry retires.
- Forwarding for entry[0], rs1 and rs2 independently: select the smallest k in 1..DEPTH-1 whose entry is a writer with rd matching the source and use flag set; none → 0.
  - fwd_sel = 0 whenever entry[0] is invalid or the source is x0.
  - A load at k < DEPTH-1 is never selected; load_use guarantees this cannot happen.
- Counters:
  - stall_count +1 per cycle with stall_id && !flush_id.
  - flush_count +1 per redirect event.
  - Both saturate at all-ones and do not wrap.
- Reset mid-stall: reset wins; the next cycle starts with the tracker empty and no stall.

Decomposition:
- Shared package (cpu_pkg): REG_AW, x0 constant, the tracker entry struct typedef and the forwarding encoding (FWD_RB = 0).
- Sub-module sat_counter (parameter W, inputs inc and clear): instantiated twice for the performance counters.

Test Plan:
- Dependent ALU pair: add x5 then sub x6,x5,x1 back-to-back → fwd_sel_rs1 = 1 for sub in EX; no stall; stall_count stays 0.
- Load-use: lw x7 then add x8,x7,x7 → one cycle of stall_if/stall_id/bubble_ex.
  - Then fwd_sel_rs1 = fwd_sel_rs2 = 2 (WB, DEPTH = 3); stall_count = 1.
- x0 destination: addi x0 then use x0 → no stall, fwd_sel = 0.
- Taken branch: ex_redirect pulse → flush_if = flush_id = bubble_ex = 1 for one cycle; flush_count = 1.
  - Concurrent load_use is suppressed.
- Memory wait: sw reaches MEM, mem_done low 3 cycles → freeze_back high exactly 3 cycles and the tracker is unchanged.
  - ex_redirect raised during the wait is acted on only on the release cycle.
- DEPTH = 5 build with writers at k = 1 and 3 to the same rd → selects 1.
  - Saturation: preload counter to all-ones, stall again → stays all-ones.
  - rst low during a stall → all outputs 0 next cycle.
